// File: rtl/mux_arb_pkg.sv
// Shared definitions for the round-robin burst arbiter.
//   NUM_PORTS / SEL_W : requester count and grant-index width
//   state_e           : arbiter FSM encoding
//   next_rr()         : round-robin winner search starting at ptr
package mux_arb_pkg;

  localparam int unsigned NUM_PORTS = 8;
  localparam int unsigned SEL_W     = 3;

  typedef enum logic {
    IDLE,
    GRANT
  } state_e;

  // First set bit of valid searching upward from ptr, wrapping 7->0.
  // With no bit set the result is ptr (the caller only uses it when |valid).
  function automatic logic [SEL_W-1:0] next_rr(input logic [NUM_PORTS-1:0] valid,
                                               input logic [SEL_W-1:0]     ptr);
    logic [SEL_W-1:0] win;
    logic [SEL_W-1:0] idx;
    logic             found;
    win   = ptr;
    found = 1'b0;
    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
      idx = ptr + SEL_W'(k);
      if (!found && valid[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/data_mux8.sv
// Purely combinational 8:1 data multiplexer.
//   in_data  : eight WIDTH-bit lanes, lane i at [i*WIDTH +: WIDTH]
//   sel      : lane select
//   out_data : selected lane
module data_mux8
  import mux_arb_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [NUM_PORTS*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]           sel,
  output logic [WIDTH-1:0]           out_data
);

  always_comb begin
    out_data = in_data[sel*WIDTH +: WIDTH];
  end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin burst arbiter: locks the mux onto one requester for a whole
// burst, forwards its beats, then rotates priority past the winner.
//   clock, reset      : rising-edge clock, async active-low reset
//   io_in_*           : eight valid/ready/last/data requester streams
//   io_out_*          : single muxed output stream
//   io_sel, io_busy   : registered grant index / grant-held flag
//   io_trunc          : one-cycle pulse after a forced (MAX_BEATS) release
module rr_mux_arbiter
  import mux_arb_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MAX_BEATS = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_PORTS-1:0]       io_in_valid,
  input  logic [NUM_PORTS-1:0]       io_in_last,
  input  logic [NUM_PORTS*WIDTH-1:0] io_in_data,
  output logic [NUM_PORTS-1:0]       io_in_ready,
  output logic                       io_out_valid,
  output logic                       io_out_last,
  output logic [WIDTH-1:0]           io_out_data,
  input  logic                       io_out_ready,
  output logic [SEL_W-1:0]           io_sel,
  output logic                       io_busy,
  output logic                       io_trunc
);

  localparam int unsigned      CNT_W    = $clog2(MAX_BEATS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BEATS - 1);

  state_e           state_q, state_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             trunc_q, trunc_d;

  logic granted;
  logic forced;
  logic xfer;

  data_mux8 #(.WIDTH(WIDTH)) u_mux (
    .in_data  (io_in_data),
    .sel      (sel_q),
    .out_data (io_out_data)
  );

  always_comb begin
    granted      = (state_q == GRANT);
    forced       = granted && (cnt_q == LAST_CNT);
    io_out_valid = granted && io_in_valid[sel_q];
    io_out_last  = granted && (io_in_last[sel_q] || (cnt_q == LAST_CNT));
    io_in_ready  = '0;
    if (granted) io_in_ready[sel_q] = io_out_ready;
    xfer         = io_out_valid && io_out_ready;

    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    trunc_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (|io_in_valid) begin
          sel_d   = next_rr(io_in_valid, ptr_q);
          cnt_d   = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (xfer) begin
          if (io_out_last) begin
            // Counter is cleared rather than incremented on release so it
            // never wraps even when MAX_BEATS fills its width.
            cnt_d   = '0;
            ptr_d   = sel_q + SEL_W'(1);
            state_d = IDLE;
            trunc_d = forced && !io_in_last[sel_q];
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
      cnt_q   <= '0;
      trunc_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      trunc_q <= trunc_d;
    end
  end

  always_comb begin
    io_sel   = sel_q;
    io_busy  = (state_q == GRANT);
    io_trunc = trunc_q;
  end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Scoreboard bench for rr_mux_arbiter (MAX_BEATS = 4). Requester sources are
// per-port beat queues; expected output beats are queued when stimulus is
// issued and a negedge monitor pops/compares on every output transfer.
module tb_rr_mux_arbiter;

  typedef struct {
    logic [7:0] d;
    logic       l;
  } beat_t;

  typedef struct {
    logic [2:0] sel;
    logic [7:0] d;
    logic       l;
  } exp_t;

  logic        clock;
  logic        reset;
  logic [7:0]  io_in_valid;
  logic [7:0]  io_in_last;
  logic [63:0] io_in_data;
  logic [7:0]  io_in_ready;
  logic        io_out_valid;
  logic        io_out_last;
  logic [7:0]  io_out_data;
  logic        io_out_ready;
  logic [2:0]  io_sel;
  logic        io_busy;
  logic        io_trunc;

  beat_t srcq[8][$];
  exp_t  expq[$];
  int    xfer_cyc[$];
  int    cyc;
  int    errors;
  int    checks;
  logic [7:0] hs;

  rr_mux_arbiter #(.WIDTH(8), .MAX_BEATS(4)) dut (
    .clock        (clock),
    .reset        (reset),
    .io_in_valid  (io_in_valid),
    .io_in_last   (io_in_last),
    .io_in_data   (io_in_data),
    .io_in_ready  (io_in_ready),
    .io_out_valid (io_out_valid),
    .io_out_last  (io_out_last),
    .io_out_data  (io_out_data),
    .io_out_ready (io_out_ready),
    .io_sel       (io_sel),
    .io_busy      (io_busy),
    .io_trunc     (io_trunc)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    cyc = 0;
    forever begin
      @(posedge clock);
      cyc++;
    end
  end

  function automatic void drive_inputs();
    for (int i = 0; i < 8; i++) begin
      if (srcq[i].size() > 0) begin
        io_in_valid[i]        = 1'b1;
        io_in_last[i]         = srcq[i][0].l;
        io_in_data[i*8 +: 8]  = srcq[i][0].d;
      end else begin
        io_in_valid[i]        = 1'b0;
        io_in_last[i]         = 1'b0;
        io_in_data[i*8 +: 8]  = 8'h00;
      end
    end
  endfunction

  task automatic push_src(input int p, input logic [7:0] d, input logic l);
    beat_t b;
    b.d = d;
    b.l = l;
    srcq[p].push_back(b);
  endtask

  task automatic push_exp(input logic [2:0] s, input logic [7:0] d, input logic l);
    exp_t e;
    e.sel = s;
    e.d   = d;
    e.l   = l;
    expq.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Source driver: handshake sampled at negedge, beat popped after the edge.
  initial begin
    hs = '0;
    forever begin
      @(negedge clock);
      hs = io_in_ready & io_in_valid;
      @(posedge clock);
      #1;
      for (int i = 0; i < 8; i++)
        if (hs[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
      hs = '0;
      drive_inputs();
    end
  end

  // Monitor / scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (io_out_valid && io_out_ready) begin
        xfer_cyc.push_back(cyc);
        if (expq.size() == 0) begin
          chk("unexpected_beat", {21'h0, io_sel, io_out_data}, 32'hFFFF_FFFF);
        end else begin
          e = expq.pop_front();
          chk("beat{sel,data,last}", {20'h0, io_sel, io_out_data, io_out_last},
              {20'h0, e.sel, e.d, e.l});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"},  {24'h0, io_in_ready}, 32'h0);
    chk({tag, "_out_valid"}, {31'h0, io_out_valid}, 32'h0);
    chk({tag, "_out_last"},  {31'h0, io_out_last}, 32'h0);
    chk({tag, "_busy"},      {31'h0, io_busy}, 32'h0);
    chk({tag, "_trunc"},     {31'h0, io_trunc}, 32'h0);
    chk({tag, "_sel"},       {29'h0, io_sel}, 32'h0);
  endtask

  initial begin
    errors       = 0;
    checks       = 0;
    reset        = 1'b0;
    io_out_ready = 1'b1;
    io_in_valid  = '0;
    io_in_last   = '0;
    io_in_data   = '0;
    drive_inputs();
    step(2);
    chk_reset_outputs("reset");
    reset = 1'b1;
    step(1);

    // Single requester, 3-beat burst.
    push_src(2, 8'hA1, 1'b0); push_src(2, 8'hA2, 1'b0); push_src(2, 8'hA3, 1'b1);
    push_exp(3'd2, 8'hA1, 1'b0); push_exp(3'd2, 8'hA2, 1'b0); push_exp(3'd2, 8'hA3, 1'b1);
    drive_inputs();
    step(1);
    chk("single_sel",  {29'h0, io_sel}, 32'd2);
    chk("single_busy", {31'h0, io_busy}, 32'd1);
    chk("single_data", {24'h0, io_out_data}, 32'hA1);
    step(3);
    chk("single_busy_end", {31'h0, io_busy}, 32'd0);

    // Round-robin fairness from ptr 0.
    reset = 1'b0;
    step(1);
    reset = 1'b1;
    step(1);
    xfer_cyc.delete();
    for (int i = 0; i < 8; i++) begin
      push_src(i, 8'h10 + 8'(i), 1'b1);
      push_exp(3'(i), 8'h10 + 8'(i), 1'b1);
    end
    push_src(0, 8'h20, 1'b1);
    push_exp(3'd0, 8'h20, 1'b1);
    drive_inputs();
    step(20);
    chk("rr_beats", xfer_cyc.size(), 32'd9);
    for (int i = 1; i < xfer_cyc.size(); i++)
      chk("rr_grant_spacing", xfer_cyc[i] - xfer_cyc[i-1], 32'd2);

    // Backpressure on requester 5.
    io_out_ready = 1'b0;
    push_src(5, 8'h55, 1'b1);
    push_exp(3'd5, 8'h55, 1'b1);
    drive_inputs();
    step(1);
    chk("bp_sel",   {29'h0, io_sel}, 32'd5);
    chk("bp_valid", {31'h0, io_out_valid}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      chk("bp_in_ready", {24'h0, io_in_ready}, 32'h00);
      chk("bp_data",     {24'h0, io_out_data}, 32'h55);
      step(1);
    end
    io_out_ready = 1'b1;
    #1;
    chk("bp_in_ready_rel", {24'h0, io_in_ready}, 32'h20);
    step(1);
    chk("bp_busy_end", {31'h0, io_busy}, 32'd0);

    // Forced release (MAX_BEATS = 4) with requester 3 waiting.
    for (int i = 0; i < 6; i++) push_src(1, 8'h11 + 8'(i), 1'b0);
    push_src(3, 8'h33, 1'b1);
    push_exp(3'd1, 8'h11, 1'b0); push_exp(3'd1, 8'h12, 1'b0);
    push_exp(3'd1, 8'h13, 1'b0); push_exp(3'd1, 8'h14, 1'b1);
    push_exp(3'd3, 8'h33, 1'b1);
    push_exp(3'd1, 8'h15, 1'b0); push_exp(3'd1, 8'h16, 1'b0);
    drive_inputs();
    step(1);
    chk("force_sel1", {29'h0, io_sel}, 32'd1);
    step(3);
    chk("force_last_beat4", {31'h0, io_out_last}, 32'd1);
    chk("force_trunc_pre",  {31'h0, io_trunc}, 32'd0);
    step(1);
    chk("force_trunc",      {31'h0, io_trunc}, 32'd1);
    chk("force_busy_rel",   {31'h0, io_busy}, 32'd0);
    step(1);
    chk("force_trunc_off",  {31'h0, io_trunc}, 32'd0);
    chk("force_sel3",       {29'h0, io_sel}, 32'd3);
    step(2);
    chk("force_regrant1",   {29'h0, io_sel}, 32'd1);
    step(4);
    chk("hold_busy",  {31'h0, io_busy}, 32'd1);
    chk("hold_valid", {31'h0, io_out_valid}, 32'd0);
    chk("hold_sel",   {29'h0, io_sel}, 32'd1);
    push_src(1, 8'h17, 1'b1);
    push_exp(3'd1, 8'h17, 1'b1);
    drive_inputs();
    step(2);
    chk("hold_busy_end", {31'h0, io_busy}, 32'd0);

    // Reset on the 2nd beat of a burst from requester 6.
    push_src(6, 8'h61, 1'b0); push_src(6, 8'h62, 1'b0); push_src(6, 8'h63, 1'b1);
    push_exp(3'd6, 8'h61, 1'b0);
    drive_inputs();
    step(2);
    reset = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    expq.delete();
    push_exp(3'd6, 8'h62, 1'b0);
    push_exp(3'd6, 8'h63, 1'b1);
    step(1);
    reset = 1'b1;
    step(1);
    chk("postrst_sel",  {29'h0, io_sel}, 32'd6);
    chk("postrst_busy", {31'h0, io_busy}, 32'd1);
    step(2);
    chk("postrst_busy_end", {31'h0, io_busy}, 32'd0);
    step(2);
    chk("scoreboard_empty", expq.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rr_mux_arbiter.md
# rr_mux_arbiter

Round-robin burst arbiter that shares one 8:1 data multiplexer among eight requesters. Each requester presents a valid/ready/last stream. The arbiter locks the mux select onto one requester for a whole burst, forwards its beats to a single output stream, and then rotates priority. It sits in front of the downstream consumer and is the only block that drives the mux select.

## Interface
- WIDTH, 8, data bits per requester beat
- MAX_BEATS, 16, maximum beats per grant before forced release; legal range 2..256

Ports:
- clock  in  1  sole clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low; asserted (0) clears all state immediately
- io_in_valid  in  8  per-requester beat valid
- io_in_last  in  8  per-requester end-of-burst marker, qualified by valid
- io_in_data  in  8*WIDTH  requester i occupies bits [i*WIDTH +: WIDTH]
- io_in_ready  out  8  per-requester beat accept
- io_out_valid  out  1  output beat valid
- io_out_last  out  1  output end-of-burst (natural or forced)
- io_out_data  out  WIDTH  muxed data
- io_out_ready  in  1  downstream accept
- io_sel  out  3  current grant index
- io_busy  out  1  1 while a grant is held
- io_trunc  out  1  one-cycle pulse on a forced release

## Operation
- States: IDLE, GRANT.
- IDLE:
  - io_in_ready = 0, io_out_valid = 0.
  - If any io_in_valid bit is set, the arbiter picks the first set index searching upward from ptr, wrapping 7→0.
  - It registers that index into sel, clears beat_cnt, and moves to GRANT.
- GRANT:
  - io_out_valid = io_in_valid[sel].
  - io_out_data = data slice of requester sel.
  - io_in_ready[i] = (i == sel) & io_out_ready. All other ready bits are 0.
  - A transfer is io_out_valid & io_out_ready.
- Forced release: io_out_last = io_in_last[sel] | (beat_cnt == MAX_BEATS-1).
- On a transfer:
  - beat_cnt increments.
  - If io_out_last is 1, the arbiter sets ptr = sel+1 (mod 8) and returns to IDLE.
  - io_trunc pulses in the cycle after a transfer where io_out_last was forced and io_in_last[sel] was 0.
- Grant hold: the requester may drop valid mid-burst. The grant is held indefinitely and io_out_valid follows it. No other requester is served until the burst ends.
- Data rules:
  - Data passes through unmodified.
  - beat_cnt is clog2(MAX_BEATS) bits and never wraps, because release occurs at MAX_BEATS-1.
- io_busy = (state == GRANT).

## Timing
- Reset values: state IDLE, ptr 0, sel 0, beat_cnt 0, io_in_ready 0, io_out_valid 0, io_out_last 0, io_busy 0, io_trunc 0.
- Arbitration latency: valid seen in IDLE at cycle N; first beat can transfer at cycle N+1.
- Throughput: a burst of B beats with ready held high occupies B+1 cycles, including one IDLE bubble between grants.
- Output paths from state registers to io_sel and io_busy are registered. io_out_valid, io_out_data and io_in_ready are combinational from the inputs and sel.
- Simultaneous events:
  - A last beat and new requests in the same cycle: the new requests are evaluated in the following IDLE cycle against the updated ptr.
  - The requester that just finished has the lowest priority in that evaluation.
- Reset asserted mid-burst: every output is at its reset value asynchronously. No beat is reported as transferred in that cycle. The bench must treat the partial burst as discarded.

## Structure
- Package mux_arb_pkg:
  - NUM_PORTS = 8, SEL_W = 3.
  - state enum {IDLE, GRANT}.
  - Function next_rr(valid[7:0], ptr) returning the winning index.
- Sub-module data_mux8: purely combinational 8:1 WIDTH-bit mux driven by sel. It is instantiated once and carries no state.
- Top-level holds the FSM, ptr, sel and beat_cnt registers.

## Test plan
- Single requester: reset, then io_in_valid = 0x04, burst of 3 beats 0xA1,0xA2,0xA3 with last on the third and out_ready = 1.
  - Expect io_sel = 2.
  - Expect beats at cycles N+1..N+3, io_out_last on 0xA3, io_busy low at N+4.
- Round-robin fairness: all 8 valid, 1-beat bursts (last = 1), ready = 1.
  - Expect grant order 0,1,2,3,4,5,6,7,0.
  - Expect a new grant every 2 cycles.
- Backpressure: grant requester 5, hold io_out_ready = 0 for 4 cycles.
  - Expect io_in_ready = 0x00 and the data stable.
  - After ready rises, expect io_in_ready = 0x20 and the transfer to complete.
- Forced release with MAX_BEATS = 4: requester 1 streams 6 beats with no last.
  - Expect io_out_last on beat 4 and an io_trunc pulse.
  - With requester 3 also valid, expect requester 3 granted next.
  - Requester 1 regains the grant only afterwards, and its beats 5–6 form a new burst.
- Reset mid-burst: pull reset low on the 2nd beat of a 3-beat burst from requester 6.
  - Expect all outputs at reset values immediately.
  - After release, with requester 6 still valid, expect grant 6 (ptr 0 search) one cycle later.
